q2a03_joypad_port: RTL and testbench

Q2A03_JOYPAD_PORT -- requirements
Module: q2a03_joypad_port

---
 rtl/q2a03_pkg.sv | 17 +
 rtl/q2a03_joypad_shifter.sv | 60 ++++++
 rtl/q2a03_joypad_port.sv | 75 +++++++
 tb/tb_q2a03_joypad_port.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/q2a03_pkg.sv
// Shared types and constants for the 2A03 joypad port.
// Used by q2a03_joypad_shifter and q2a03_joypad_port.
package q2a03_pkg;

  typedef logic [7:0] reg8_type;
  typedef logic [3:0] reg4_type;

  localparam logic [15:0] JOYPAD_BASE = 16'h4016;

  typedef enum logic [1:0] {
    ST_STROBE,
    ST_LATCHED,
    ST_SHIFTING,
    ST_EXHAUSTED
  } shifter_state_e;

endpackage

// File: rtl/q2a03_joypad_shifter.sv
// One joypad 4021-style shift register with strobe reload and read count.
// Reads past the eighth bit return 1.
module q2a03_joypad_shifter
  import q2a03_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     strobe,
  input  logic     rd,
  input  reg8_type buttons,
  output logic     data
);

  shifter_state_e state, state_nx;
  reg8_type       sreg, sreg_nx;
  reg4_type       cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EXHAUSTED;
      sreg  <= 8'hFF;
      cnt   <= 4'd8;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    if (strobe) begin
      state_nx = ST_STROBE;
      sreg_nx  = buttons;
      cnt_nx   = 4'd0;
    end else begin
      unique case (state)
        ST_STROBE: state_nx = ST_LATCHED;
        ST_LATCHED, ST_SHIFTING: begin
          if (rd) begin
            sreg_nx  = {1'b1, sreg[7:1]};
            cnt_nx   = cnt + 4'd1;
            state_nx = (cnt_nx == 4'd8) ? ST_EXHAUSTED
                                        : ST_SHIFTING;
          end
        end
        ST_EXHAUSTED: begin
          if (rd) sreg_nx = {1'b1, sreg[7:1]};
        end
        default: state_nx = ST_EXHAUSTED;
      endcase
    end
  end

  // While strobed the pad is transparent: A is seen live.
  assign data = (state == ST_STROBE) ? buttons[0] : sreg[0];

endmodule

// File: rtl/q2a03_joypad_port.sv
// CPU-side joypad port: bus decode, phy2 edge detect, strobe, read mux.
// Define Q2A03_JOYPAD_PAD2_EN to build the second pad shifter.
module q2a03_joypad_port
  import q2a03_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = JOYPAD_BASE,
  parameter logic [7:0]  OPEN_BUS  = 8'h40
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        G_phy2,
  input  logic [15:0] G_addr,
  input  logic        G_rdwr,
  input  logic [7:0]  G_wr_data,
  output logic [7:0]  G_rd_data,
  output logic        G_rd_en,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons
);

  localparam logic [15:0] PAD2_ADDR = BASE_ADDR + 16'd1;

  logic phy2_q;
  logic strobe;
  logic done;
  logic hit1;
  logic hit2;
  logic pad1_bit;
  logic pad2_bit;
  logic wr_unused;

  assign done = phy2_q & ~G_phy2;
  assign hit1 = (G_addr == BASE_ADDR);
  assign hit2 = (G_addr == PAD2_ADDR);
  assign wr_unused = ^G_wr_data[7:1];

  always_ff @(posedge G_clock or posedge G_reset) begin
    if (G_reset) begin
      phy2_q <= 1'b0;
      strobe <= 1'b0;
    end else begin
      phy2_q <= G_phy2;
      if (done && !G_rdwr && hit1) strobe <= G_wr_data[0];
    end
  end

  q2a03_joypad_shifter u_pad1 (
    .clk     (G_clock),
    .rst     (G_reset),
    .strobe  (strobe),
    .rd      (done & G_rdwr & hit1),
    .buttons (pad1_buttons),
    .data    (pad1_bit)
  );

`ifdef Q2A03_JOYPAD_PAD2_EN
  q2a03_joypad_shifter u_pad2 (
    .clk     (G_clock),
    .rst     (G_reset),
    .strobe  (strobe),
    .rd      (done & G_rdwr & hit2),
    .buttons (pad2_buttons),
    .data    (pad2_bit)
  );
`else
  logic pad2_unused;
  assign pad2_unused = ^pad2_buttons;
  assign pad2_bit    = 1'b0;
`endif

  assign G_rd_en   = G_phy2 & G_rdwr & (hit1 | hit2);
  assign G_rd_data = G_rd_en ? {OPEN_BUS[7:1], hit1 ? pad1_bit : pad2_bit}
                             : 8'h00;

endmodule

// File: tb/tb_q2a03_joypad_port.sv
// Randomized bench for q2a03_joypad_port with a behavioural pad model.
// Pad-2 expectations follow Q2A03_JOYPAD_PAD2_EN.
module tb_q2a03_joypad_port;

  localparam logic [15:0] BASE = 16'h4016;
  localparam logic [15:0] BASE2 = 16'h4017;
  localparam logic [7:0]  OB = 8'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phy2 = 1'b0;
  logic [15:0] addr = BASE;
  logic        rdwr = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic [7:0]  rd_data;
  logic        rd_en;
  logic [7:0]  pad1 = 8'h00;
  logic [7:0]  pad2 = 8'h00;

  // model: strobe flag, latched bytes, index of the next bit to return
  logic       strobe_m = 1'b0;
  logic [7:0] lat1 = 8'hFF;
  logic [7:0] lat2 = 8'hFF;
  int         idx1 = 8;
  int         idx2 = 8;

  logic [7:0] lit_exp = 8'h00;
  logic       lit_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  q2a03_joypad_port dut (
    .G_clock      (clk),
    .G_reset      (rst),
    .G_phy2       (phy2),
    .G_addr       (addr),
    .G_rdwr       (rdwr),
    .G_wr_data    (wr_data),
    .G_rd_data    (rd_data),
    .G_rd_en      (rd_en),
    .pad1_buttons (pad1),
    .pad2_buttons (pad2)
  );

  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [15:0] a);
    if (a == BASE) begin
      if (strobe_m) return pad1[0];
      if (idx1 < 8) return lat1[idx1];
      return 1'b1;
    end
`ifdef Q2A03_JOYPAD_PAD2_EN
    if (strobe_m) return pad2[0];
    if (idx2 < 8) return lat2[idx2];
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // single compare process, sampled 2 time units after each clock edge
  initial begin
    logic       e_en;
    logic [7:0] e_dat;
    forever begin
      @(clk);
      #2;
      e_en  = phy2 && rdwr && (addr == BASE || addr == BASE2);
      e_dat = e_en ? ((OB & 8'hFE) | {7'd0, exp_bit(addr)}) : 8'h00;
      checks++;
      if (rd_en !== e_en || rd_data !== e_dat) begin
        errors++;
        $display("FAIL model t=%0t addr=%h rdwr=%b got en=%b data=%h exp en=%b data=%h",
                 $time, addr, rdwr, rd_en, rd_data, e_en, e_dat);
      end
      if (lit_valid) begin
        checks++;
        if (rd_data !== lit_exp) begin
          errors++;
          $display("FAIL literal t=%0t addr=%h got %h exp %h",
                   $time, addr, rd_data, lit_exp);
        end
      end
    end
  end

  task automatic model_reset();
    strobe_m = 1'b0;
    idx1 = 8;
    idx2 = 8;
  endtask

  task automatic bus(input logic [15:0] a, input logic rw,
                     input logic [7:0] wd, input int lit);
    @(negedge clk);
    addr = a; rdwr = rw; wr_data = wd; phy2 = 1'b1;
    lit_exp = lit[7:0];
    lit_valid = (lit >= 0);
    repeat (2) @(negedge clk);
    phy2 = 1'b0;
    lit_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (rw) begin
      if (a == BASE && !strobe_m && idx1 < 8) idx1++;
`ifdef Q2A03_JOYPAD_PAD2_EN
      if (a == BASE2 && !strobe_m && idx2 < 8) idx2++;
`endif
    end else if (a == BASE) begin
      if (wd[0]) strobe_m = 1'b1;
      else if (strobe_m) begin
        strobe_m = 1'b0;
        lat1 = pad1; lat2 = pad2;
        idx1 = 0; idx2 = 0;
      end
    end
  endtask

  task automatic rd(input logic [15:0] a, input int lit);
    bus(a, 1'b1, 8'h00, lit);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b0, d, -1);
  endtask

  // asserted between clock edges so a synchronous reset would be seen late
  task automatic reset_pulse();
    @(posedge clk);
    #4;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] oa;
    int op;
    logic [7:0] seq;
    // read held during reset: exhausted pad returns 1
    phy2 = 1'b1; rdwr = 1'b1; addr = BASE;
    lit_exp = 8'h41; lit_valid = 1'b1;
    repeat (3) @(negedge clk);
    phy2 = 1'b0; lit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(BASE, 8'h41);

    // latch A5, ten reads
    pad1 = 8'b1010_0101;
    wr(BASE, 8'h01);
    wr(BASE, 8'h00);
    pad1 = 8'h00;
    seq = 8'b1010_0101;
    for (int i = 0; i < 10; i++)
      rd(BASE, (i < 8) ? (32'h40 | 32'(seq[i])) : 32'h41);

    // strobe held: live A, no shift
    wr(BASE, 8'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pad1 = {7'h00, 1'(i % 2 == 0)};
      rd(BASE, (i % 2 == 0) ? 32'h41 : 32'h40);
    end
    pad1 = 8'h02;
    wr(BASE, 8'h00);
    rd(BASE, 8'h40);
    rd(BASE, 8'h41);

    // relatch mid-sequence
    pad1 = 8'hFF;
    wr(BASE, 8'h01);
    wr(BASE, 8'h00);
    for (int i = 0; i < 3; i++) rd(BASE, 8'h41);
    pad1 = 8'h00;
    wr(BASE, 8'h01);
    wr(BASE, 8'h00);
    for (int i = 0; i < 8; i++) rd(BASE, 8'h40);
    rd(BASE, 8'h41);

`ifdef Q2A03_JOYPAD_PAD2_EN
    pad1 = 8'h01;
    pad2 = 8'h02;
    wr(BASE, 8'h01);
    wr(BASE, 8'h00);
    rd(BASE2, 8'h40);
    rd(BASE2, 8'h41);
    rd(BASE2, 8'h40);
    rd(BASE, 8'h41);
    rd(BASE, 8'h40);
`else
    rd(BASE2, 8'h40);
`endif

    // reset during shifting, including mid read phase
    pad1 = 8'h00;
    wr(BASE, 8'h01);
    wr(BASE, 8'h00);
    rd(BASE, 8'h40);
    rd(BASE, 8'h40);
    @(negedge clk);
    addr = BASE; rdwr = 1'b1; phy2 = 1'b1;
    lit_exp = 8'h40; lit_valid = 1'b1;
    @(posedge clk);
    #4;
    rst = 1'b1;
    model_reset();
    lit_exp = 8'h41;
    repeat (2) @(negedge clk);
    phy2 = 1'b0; lit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(BASE, 8'h41);
    wr(BASE2, 8'h01);
    rd(BASE, 8'h41);
    reset_pulse();
    rd(BASE, 8'h41);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      oa = 16'($urandom);
      if (oa == BASE || oa == BASE2) oa = 16'h2002;
      case (op)
        0: begin
          @(negedge clk);
          pad1 = 8'($urandom);
          pad2 = 8'($urandom);
        end
        1: wr(BASE, 8'($urandom));
        2: wr(BASE2, 8'($urandom));
        3: wr(oa, 8'($urandom));
        4, 5, 6: rd(BASE, -1);
        7: rd(BASE2, -1);
        8: rd(oa, -1);
        default: begin
          if ($urandom_range(0, 7) == 0) reset_pulse();
          else rd(BASE, -1);
        end
      endcase
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
